// File: rtl/uart_cmd_parser_pkg.sv
// uart_cmd_parser_pkg: shared definitions for the UART calculator command parser.
// Holds the parser state encoding, the dtype / operator / error-code values, the
// ASCII constants recognised in a frame, and a helper that maps an operator byte
// to its operator code.
package uart_cmd_parser_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFmtSp,
    StType,
    StTypeSp,
    StOpA,
    StOpB,
    StPend,
    StDiscard
  } state_e;

  // dtype values
  localparam logic [1:0] DtypeNone = 2'd0;
  localparam logic [1:0] DtypeS    = 2'd1;
  localparam logic [1:0] DtypeU    = 2'd2;

  // operator values
  localparam logic [2:0] OpNone = 3'd0;
  localparam logic [2:0] OpAdd  = 3'd1;
  localparam logic [2:0] OpSub  = 3'd2;
  localparam logic [2:0] OpMul  = 3'd3;
  localparam logic [2:0] OpDiv  = 3'd4;

  // err_code values
  localparam logic [2:0] ErrNone    = 3'd0;
  localparam logic [2:0] ErrBadChar = 3'd1;
  localparam logic [2:0] ErrEmpty   = 3'd2;
  localparam logic [2:0] ErrOvf     = 3'd3;
  localparam logic [2:0] ErrOverrun = 3'd4;
  localparam logic [2:0] ErrTimeout = 3'd5;

  // ASCII constants
  localparam logic [7:0] AsciiSp    = 8'h20;
  localparam logic [7:0] AsciiCr    = 8'h0D;
  localparam logic [7:0] AsciiLf    = 8'h0A;
  localparam logic [7:0] AsciiI     = 8'h49;
  localparam logic [7:0] AsciiS     = 8'h53;
  localparam logic [7:0] AsciiU     = 8'h55;
  localparam logic [7:0] AsciiEq    = 8'h3D;
  localparam logic [7:0] AsciiPlus  = 8'h2B;
  localparam logic [7:0] AsciiMinus = 8'h2D;
  localparam logic [7:0] AsciiStar  = 8'h2A;
  localparam logic [7:0] AsciiSlash = 8'h2F;

  // Returns OpNone when the byte is not one of the four operator characters.
  function automatic logic [2:0] op_decode(input logic [7:0] b);
    logic [2:0] op;
    op = OpNone;
    case (b)
      AsciiPlus:  op = OpAdd;
      AsciiMinus: op = OpSub;
      AsciiStar:  op = OpMul;
      AsciiSlash: op = OpDiv;
      default:    op = OpNone;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// uart_cmd_parser_if: byte-stream input, parsed-command output and error report of
// the command parser.
//   rx_data/rx_valid          received byte and its one-cycle strobe (no backpressure)
//   dtype/operator/src1/src2  parsed command, held while out_valid
//   out_valid/out_ready       command handshake towards the ALU
//   err_valid/err_code        one-cycle error pulse, code held until the next error
// Modports: master = byte source / ALU side, slave = parser.
interface uart_cmd_parser_if #(
  parameter int unsigned DATA_W = 16
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [1:0]        dtype;
  logic [2:0]        operator;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic              out_valid;
  logic              out_ready;
  logic              err_valid;
  logic [2:0]        err_code;

  modport master (
    output rx_data, rx_valid, out_ready,
    input  dtype, operator, src1, src2, out_valid, err_valid, err_code
  );

  modport slave (
    input  rx_data, rx_valid, out_ready,
    output dtype, operator, src1, src2, out_valid, err_valid, err_code
  );
endinterface

// File: rtl/uart_cmd_parser_hex_ascii_decode.sv
// hex_ascii_decode: combinational ASCII hex-digit decoder.
//   rx_byte_i  input byte
//   is_hex_o   1 when the byte is 0-9, A-F or a-f
//   nibble_o   digit value (0 when not a hex digit)
module hex_ascii_decode (
  input  logic [7:0] rx_byte_i,
  output logic       is_hex_o,
  output logic [3:0] nibble_o
);

  always_comb begin
    is_hex_o = 1'b0;
    nibble_o = 4'd0;
    if (rx_byte_i >= 8'h30 && rx_byte_i <= 8'h39) begin
      is_hex_o = 1'b1;
      nibble_o = rx_byte_i[3:0];
    end else if ((rx_byte_i >= 8'h41 && rx_byte_i <= 8'h46) ||
                 (rx_byte_i >= 8'h61 && rx_byte_i <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so adding 9 yields 10..15
      is_hex_o = 1'b1;
      nibble_o = rx_byte_i[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: parses "I <S|U> <hexA><op><hexB>=" frames from a UART byte stream
// into an ALU command held on a valid/ready output, and reports malformed frames.
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   uart_cmd_parser_if.slave: rx_data/rx_valid in, command + out_valid/out_ready,
//         err_valid/err_code out
// Optional feature: define UART_CMD_PARSER_TIMEOUT_EN to abort a partial frame after
// TIMEOUT_CYC idle cycles with error code TIMEOUT.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic                clk,
  input  logic                rst,
  uart_cmd_parser_if.slave    bus
);

  localparam int unsigned NDIG = DATA_W / 4;
  localparam int unsigned CntW = $clog2(NDIG + 1);

  if (DATA_W < 4 || DATA_W > 64 || (DATA_W % 4) != 0) begin : gen_bad_data_w
    $error("DATA_W must be a multiple of 4 in the range 4..64");
  end
  if (TIMEOUT_CYC < 2) begin : gen_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_a_q, acc_a_d;
  logic [DATA_W-1:0] acc_b_q, acc_b_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        type_q, type_d;
  logic [2:0]        op_q, op_d;
  logic [1:0]        dtype_q, dtype_d;
  logic [2:0]        operator_q, operator_d;
  logic [DATA_W-1:0] src1_q, src1_d;
  logic [DATA_W-1:0] src2_q, src2_d;
  logic              out_valid_q, out_valid_d;
  logic              err_valid_q, err_valid_d;
  logic [2:0]        err_code_q, err_code_d;

`ifdef UART_CMD_PARSER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC);
  logic [TmoW-1:0]   tmo_q, tmo_d;
`endif

  logic              is_hex;
  logic [3:0]        nibble;
  logic [2:0]        op_code;
  logic              is_ws;
  logic              in_frame;
  logic              raise;
  logic [2:0]        raise_code;
  logic [DATA_W-1:0] acc_shift;

  hex_ascii_decode u_hex_decode (
    .rx_byte_i (bus.rx_data),
    .is_hex_o  (is_hex),
    .nibble_o  (nibble)
  );

  assign op_code  = op_decode(bus.rx_data);
  assign is_ws    = (bus.rx_data == AsciiSp) || (bus.rx_data == AsciiCr) ||
                    (bus.rx_data == AsciiLf);
  assign in_frame = (state_q == StFmtSp) || (state_q == StType) || (state_q == StTypeSp) ||
                    (state_q == StOpA) || (state_q == StOpB);

  // One decoder/shifter serves both operands; only the selected accumulator is written.
  assign acc_shift = ((state_q == StOpB) ? acc_b_q : acc_a_q) << 4 | DATA_W'(nibble);

  always_comb begin
    state_d     = state_q;
    acc_a_d     = acc_a_q;
    acc_b_d     = acc_b_q;
    cnt_d       = cnt_q;
    type_d      = type_q;
    op_d        = op_q;
    dtype_d     = dtype_q;
    operator_d  = operator_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    out_valid_d = out_valid_q;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    raise       = 1'b0;
    raise_code  = ErrNone;
`ifdef UART_CMD_PARSER_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif

    if (bus.rx_valid) begin
      unique case (state_q)
        StIdle: begin
          if (bus.rx_data == AsciiI) begin
            state_d = StFmtSp;
          end else if (!is_ws) begin
            raise      = 1'b1;
            raise_code = ErrBadChar;
          end
        end
        StFmtSp: begin
          if (bus.rx_data == AsciiSp) begin
            state_d = StType;
          end else begin
            raise      = 1'b1;
            raise_code = ErrBadChar;
          end
        end
        StType: begin
          if (bus.rx_data == AsciiS) begin
            type_d  = DtypeS;
            state_d = StTypeSp;
          end else if (bus.rx_data == AsciiU) begin
            type_d  = DtypeU;
            state_d = StTypeSp;
          end else begin
            raise      = 1'b1;
            raise_code = ErrBadChar;
          end
        end
        StTypeSp: begin
          if (bus.rx_data == AsciiSp) begin
            acc_a_d = '0;
            cnt_d   = '0;
            state_d = StOpA;
          end else begin
            raise      = 1'b1;
            raise_code = ErrBadChar;
          end
        end
        StOpA, StOpB: begin
          if (is_hex) begin
            if (cnt_q == CntW'(NDIG)) begin
              raise      = 1'b1;
              raise_code = ErrOvf;
            end else begin
              if (state_q == StOpA) acc_a_d = acc_shift;
              else                  acc_b_d = acc_shift;
              cnt_d = cnt_q + CntW'(1);
            end
          end else if (state_q == StOpA && op_code != OpNone) begin
            if (cnt_q != '0) begin
              op_d    = op_code;
              acc_b_d = '0;
              cnt_d   = '0;
              state_d = StOpB;
            end else begin
              raise      = 1'b1;
              raise_code = ErrEmpty;
            end
          end else if (state_q == StOpB && bus.rx_data == AsciiEq) begin
            if (cnt_q != '0) begin
              src1_d      = acc_a_q;
              src2_d      = acc_b_q;
              dtype_d     = type_q;
              operator_d  = op_q;
              out_valid_d = 1'b1;
              state_d     = StPend;
            end else begin
              raise      = 1'b1;
              raise_code = ErrEmpty;
            end
          end else begin
            raise      = 1'b1;
            raise_code = ErrBadChar;
          end
        end
        StPend: begin
          // Byte is dropped; the held command is untouched.
          raise      = 1'b1;
          raise_code = ErrOverrun;
        end
        StDiscard: begin
          if (bus.rx_data == AsciiEq) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    if (raise && in_frame) state_d = StDiscard;

    // Handshake wins over a same-cycle overrun: the command still retires.
    if (state_q == StPend && out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
      state_d     = StIdle;
    end

`ifdef UART_CMD_PARSER_TIMEOUT_EN
    if (bus.rx_valid) begin
      tmo_d = '0;
    end else if (in_frame || state_q == StDiscard) begin
      if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
        raise      = 1'b1;
        raise_code = ErrTimeout;
        acc_a_d    = '0;
        acc_b_d    = '0;
        cnt_d      = '0;
        tmo_d      = '0;
        state_d    = StIdle;
      end else begin
        tmo_d = tmo_q + TmoW'(1);
      end
    end
`endif

    if (raise) begin
      err_valid_d = 1'b1;
      err_code_d  = raise_code;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_a_q     <= '0;
      acc_b_q     <= '0;
      cnt_q       <= '0;
      type_q      <= DtypeNone;
      op_q        <= OpNone;
      dtype_q     <= DtypeNone;
      operator_q  <= OpNone;
      src1_q      <= '0;
      src2_q      <= '0;
      out_valid_q <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= ErrNone;
`ifdef UART_CMD_PARSER_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      acc_a_q     <= acc_a_d;
      acc_b_q     <= acc_b_d;
      cnt_q       <= cnt_d;
      type_q      <= type_d;
      op_q        <= op_d;
      dtype_q     <= dtype_d;
      operator_q  <= operator_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      out_valid_q <= out_valid_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
`ifdef UART_CMD_PARSER_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign bus.dtype     = dtype_q;
  assign bus.operator  = operator_q;
  assign bus.src1      = src1_q;
  assign bus.src2      = src2_q;
  assign bus.out_valid = out_valid_q;
  assign bus.err_valid = err_valid_q;
  assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: frames are built from chosen values (valid) or
// chosen defects (malformed); the expected command or error code follows from how each
// frame was built and is queued before the bytes are sent. A monitor compares DUT
// outputs against the queue heads.
module tb_uart_cmd_parser;
  import uart_cmd_parser_pkg::*;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned NDIG        = DATA_W / 4;
  localparam int unsigned TIMEOUT_CYC = 50;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [1:0]        dtype;
    logic [2:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_cmd_parser_if #(.DATA_W(DATA_W)) bus ();

  uart_cmd_parser #(
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  cmd_t       exp_cmd_q[$];
  logic [2:0] exp_err_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  bq_t        fq;
  cmd_t       mon_c;
  logic [2:0] mon_e;

  logic [7:0] ws_chr [3] = '{8'h20, 8'h0D, 8'h0A};
  logic [7:0] op_chr [4] = '{8'h2B, 8'h2D, 8'h2A, 8'h2F};
  logic [7:0] bad_chr[4] = '{8'h67, 8'h47, 8'h20, 8'h78};  // g G space x
  logic [7:0] idle_bad[4] = '{8'h7A, 8'h3D, 8'h35, 8'h2B}; // z = 5 +

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid) begin
        n_checks++;
        if (exp_cmd_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_cmd got src1=%h src2=%h with no command expected",
                   bus.src1, bus.src2);
        end else begin
          mon_c = exp_cmd_q[0];
          if (bus.src1 !== mon_c.a || bus.src2 !== mon_c.b || bus.dtype !== mon_c.dtype ||
              bus.operator !== mon_c.op) begin
            n_errors++;
            $display("FAIL cmd got src1=%h src2=%h dtype=%0d op=%0d want src1=%h src2=%h dtype=%0d op=%0d",
                     bus.src1, bus.src2, bus.dtype, bus.operator,
                     mon_c.a, mon_c.b, mon_c.dtype, mon_c.op);
          end
          if (bus.out_ready) void'(exp_cmd_q.pop_front());
        end
      end
      if (bus.err_valid) begin
        n_checks++;
        if (exp_err_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_err got code=%0d with no error expected", bus.err_code);
        end else begin
          mon_e = exp_err_q.pop_front();
          if (bus.err_code !== mon_e) begin
            n_errors++;
            $display("FAIL err_code got %0d want %0d", bus.err_code, mon_e);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_fq(input bit gaps);
    for (int i = 0; i < fq.size(); i++) begin
      if (gaps) idle($urandom_range(0, 2));
      send_byte(fq[i]);
    end
  endtask

  task automatic set_str(input string s);
    fq = {};
    for (int i = 0; i < s.len(); i++) fq.push_back(s[i]);
  endtask

  function automatic logic [7:0] hex_char(input int unsigned n);
    if (n < 10) return 8'(48 + n);
    return 8'((($urandom_range(0, 1) != 0) ? 65 : 97) + n - 10);
  endfunction

  task automatic add_digits(input int n, output logic [DATA_W-1:0] v);
    int unsigned nib;
    v = '0;
    for (int i = 0; i < n; i++) begin
      nib = $urandom_range(0, 15);
      v   = (v << 4) | DATA_W'(nib);
      fq.push_back(hex_char(nib));
    end
  endtask

  // Sends fq ending in '=' and retires the command. ovr: 0 none, 1 byte while stalled,
  // 2 byte on the handshake cycle.
  task automatic run_valid(input cmd_t c, input int stall, input int ovr);
    exp_cmd_q.push_back(c);
    bus.out_ready = (stall == 0);
    send_fq(1'b1);
    chk("out_valid_rise", 64'(bus.out_valid), 64'd1);
    for (int k = 0; k < stall; k++) begin
      if (ovr == 1 && k == 0) begin
        exp_err_q.push_back(ErrOverrun);
        send_byte(8'h49);
      end else begin
        idle(1);
      end
    end
    bus.out_ready = 1'b1;
    if (ovr == 2) begin
      exp_err_q.push_back(ErrOverrun);
      send_byte(8'h49);
    end else begin
      idle(1);
    end
    chk("out_valid_fall", 64'(bus.out_valid), 64'd0);
  endtask

  task automatic run_err(input logic [2:0] code);
    exp_err_q.push_back(code);
    send_fq(1'b1);
  endtask

  task automatic rand_valid();
    cmd_t c;
    logic s;
    int   oi, st, ov;
    fq = {};
    repeat ($urandom_range(0, 2)) fq.push_back(ws_chr[$urandom_range(0, 2)]);
    s  = 1'($urandom_range(0, 1));
    oi = $urandom_range(0, 3);
    fq.push_back(8'h49);
    fq.push_back(8'h20);
    fq.push_back(s ? 8'h53 : 8'h55);
    fq.push_back(8'h20);
    add_digits($urandom_range(1, NDIG), c.a);
    fq.push_back(op_chr[oi]);
    add_digits($urandom_range(1, NDIG), c.b);
    fq.push_back(8'h3D);
    c.dtype = s ? 2'd1 : 2'd2;
    c.op    = 3'(oi + 1);
    st = $urandom_range(0, 4);
    ov = $urandom_range(0, 2);
    if (st == 0 && ov == 1) ov = 2;
    run_valid(c, st, ov);
  endtask

  task automatic rand_err(input int kind);
    logic [DATA_W-1:0] v;
    logic [2:0]        code;
    fq = {};
    code = ErrBadChar;
    case (kind)
      0: fq.push_back(idle_bad[$urandom_range(0, 3)]);
      1: set_str("IU12+3=");
      2: set_str("I X 1+2=");
      3: set_str("I S1+2=");
      4: begin
        set_str("I U ");
        fq.push_back(op_chr[$urandom_range(0, 3)]);
        fq.push_back(8'h35);
        fq.push_back(8'h3D);
        code = ErrEmpty;
      end
      5: begin
        set_str("I U ");
        add_digits(NDIG + 1, v);
        fq.push_back(8'h2D);
        fq.push_back(8'h31);
        fq.push_back(8'h3D);
        code = ErrOvf;
      end
      6: begin
        set_str("I S 1");
        fq.push_back(bad_chr[$urandom_range(0, 3)]);
        fq.push_back(8'h2B);
        fq.push_back(8'h31);
        fq.push_back(8'h3D);
      end
      7: set_str("I U 1+2+3=");
      8: set_str("I U 1==");  // '=' in A is bad; the second '=' ends the discard
      default: begin
        set_str("I U 5+==");
        code = ErrEmpty;
      end
    endcase
    run_err(code);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_data   = 8'h00;
    bus.rx_valid  = 1'b0;
    bus.out_ready = 1'b0;
    idle(3);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_err_valid", 64'(bus.err_valid), 64'd0);
    chk("rst_err_code", 64'(bus.err_code), 64'd0);
    chk("rst_src1", 64'(bus.src1), 64'd0);
    chk("rst_src2", 64'(bus.src2), 64'd0);
    chk("rst_dtype", 64'(bus.dtype), 64'd0);
    chk("rst_operator", 64'(bus.operator), 64'd0);
    rst = 1'b0;
    idle(2);

    set_str("I S 12+3F=");
    run_valid({2'd1, 3'd1, 16'h0012, 16'h003F}, 0, 0);
    set_str("I U ffff*a=");
    run_valid({2'd2, 3'd3, 16'hFFFF, 16'h000A}, 5, 0);
    set_str("I U 12345-1=");
    run_err(ErrOvf);
    set_str("I U 1/1=");
    run_valid({2'd2, 3'd4, 16'h0001, 16'h0001}, 0, 0);
    set_str("I U +5=");
    run_err(ErrEmpty);
    set_str("I X 1+2=");
    run_err(ErrBadChar);
    set_str("I U 1==");
    run_err(ErrBadChar);
    set_str("I S abcd-FFFF=");
    run_valid({2'd1, 3'd2, 16'hABCD, 16'hFFFF}, 3, 1);
    set_str("I U 0/7=");
    run_valid({2'd2, 3'd4, 16'h0000, 16'h0007}, 0, 2);

    set_str("I U 12");
    send_fq(1'b0);
`ifdef UART_CMD_PARSER_TIMEOUT_EN
    exp_err_q.push_back(ErrTimeout);
    idle(TIMEOUT_CYC + 10);
    set_str("I U 12+3=");
    run_valid({2'd2, 3'd1, 16'h0012, 16'h0003}, 0, 0);
`else
    idle(TIMEOUT_CYC + 10);
    set_str("+3=");
    run_valid({2'd2, 3'd1, 16'h0012, 16'h0003}, 0, 0);
`endif

    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 2) != 0) rand_valid();
      else rand_err($urandom_range(0, 9));
    end

    // Reset in the middle of operand B, after a command and an error left state behind.
    set_str("I S 9*9=");
    run_valid({2'd1, 3'd3, 16'h0009, 16'h0009}, 0, 0);
    set_str("I X=");
    run_err(ErrBadChar);
    idle(2);
    set_str("I U 12+3");
    send_fq(1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_err_code", 64'(bus.err_code), 64'd0);
    chk("midrst_src1", 64'(bus.src1), 64'd0);
    chk("midrst_src2", 64'(bus.src2), 64'd0);
    chk("midrst_dtype", 64'(bus.dtype), 64'd0);
    chk("midrst_operator", 64'(bus.operator), 64'd0);
    idle(2);
    chk("midrst_err_valid", 64'(bus.err_valid), 64'd0);
    rst = 1'b0;
    idle(1);
    set_str("I S 7+8=");
    run_valid({2'd1, 3'd1, 16'h0007, 16'h0008}, 0, 0);

    idle(10);
    chk("cmd_queue_drained", 64'(exp_cmd_q.size()), 64'd0);
    chk("err_queue_drained", 64'(exp_err_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
